// File: rtl/uart_wb_master_pkg.sv
// Shared constants, state encodings and the baud divisor helper for the UART-to-wishbone bridge.
package uart_wb_master_pkg;

    localparam logic [7:0] CMD_WRITE = 8'h57;
    localparam logic [7:0] CMD_READ  = 8'h52;
    localparam logic [7:0] RSP_ACK   = 8'h06;
    localparam logic [7:0] RSP_NAK   = 8'h15;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_REQUEST,
        ST_WAIT_ACK,
        ST_RESP
    } state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    // Divisor below 4 leaves no room for the half-bit start check.
    function automatic int calc_div(input int clk_hz, input int baud);
        int d;
        d = clk_hz / baud;
        return (d < 4) ? 4 : d;
    endfunction

endpackage

// File: rtl/uart_wb_master_if.sv
// Pipelined wishbone master bus plus the response byte valid/ready port.
interface uart_wb_master_if;

    logic        o_wb_cyc;
    logic        o_wb_stb;
    logic        o_wb_we;
    logic [31:0] o_wb_addr;
    logic [31:0] o_wb_data;
    logic [31:0] i_wb_data;
    logic        i_wb_stall;
    logic        i_wb_ack;
    logic        o_resp_valid;
    logic [7:0]  o_resp_data;
    logic        i_resp_ready;

    modport master (
        output o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_data,
        input  i_wb_data, i_wb_stall, i_wb_ack,
        output o_resp_valid, o_resp_data,
        input  i_resp_ready
    );

    modport slave (
        input  o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_data,
        output i_wb_data, i_wb_stall, i_wb_ack,
        input  o_resp_valid, o_resp_data,
        output i_resp_ready
    );

endinterface

// File: rtl/uart_wb_master_uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, half-bit start recheck, mid-bit sampling.
module uart_rx
    import uart_wb_master_pkg::*;
#(
    parameter int DIV = 10
) (
    input  logic       i_wb_clk,
    input  logic       i_wb_rst,
    input  logic       i_rx,
    output logic [7:0] o_data,
    output logic       o_valid,
    output logic       o_err
);

    localparam int CW = $clog2(DIV);

    rx_state_t     state;
    logic          rx_meta;
    logic          rx_sync;
    logic          rx_prev;
    logic [CW-1:0] baud_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;

    always_ff @(posedge i_wb_clk or posedge i_wb_rst) begin
        if (i_wb_rst) begin
            state    <= RX_IDLE;
            rx_meta  <= 1'b1;
            rx_sync  <= 1'b1;
            rx_prev  <= 1'b1;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            o_data   <= '0;
            o_valid  <= 1'b0;
            o_err    <= 1'b0;
        end else begin
            o_valid <= 1'b0;
            o_err   <= 1'b0;
            rx_meta <= i_rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
            case (state)
                RX_IDLE: begin
                    if (rx_prev && !rx_sync) begin
                        baud_cnt <= CW'(DIV / 2 - 1);
                        state    <= RX_START;
                    end
                end
                RX_START: begin
                    if (baud_cnt == '0) begin
                        // A glitch that is gone by mid-bit is not a start bit.
                        if (!rx_sync) begin
                            baud_cnt <= CW'(DIV - 1);
                            bit_cnt  <= '0;
                            state    <= RX_DATA;
                        end else begin
                            state <= RX_IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt - 1'b1;
                    end
                end
                RX_DATA: begin
                    if (baud_cnt == '0) begin
                        shreg    <= {rx_sync, shreg[7:1]};
                        baud_cnt <= CW'(DIV - 1);
                        if (bit_cnt == 3'd7) begin
                            state <= RX_STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt - 1'b1;
                    end
                end
                RX_STOP: begin
                    if (baud_cnt == '0) begin
                        if (rx_sync) begin
                            o_valid <= 1'b1;
                            o_data  <= shreg;
                        end else begin
                            o_err <= 1'b1;
                        end
                        state <= RX_IDLE;
                    end else begin
                        baud_cnt <= baud_cnt - 1'b1;
                    end
                end
                default: state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart_wb_master.sv
// Host command bridge: UART frames in, single wishbone read/write out, response bytes back.
//   state       | meaning
//   ST_IDLE     | waiting for a 'W' or 'R' command byte
//   ST_ADDR     | waiting for the address byte
//   ST_DATA     | collecting four little-endian write data bytes
//   ST_REQUEST  | stb asserted until the slave stops stalling
//   ST_WAIT_ACK | cycle open, waiting for ack or timeout
//   ST_RESP     | draining response bytes to the transmitter
module uart_wb_master
    import uart_wb_master_pkg::*;
#(
    parameter int CLK_HZ  = 48000000,
    parameter int BAUD    = 115200,
    parameter int TIMEOUT = 255
) (
    input  logic               i_wb_clk,
    input  logic               i_wb_rst,
    input  logic               i_uart_rx,
    uart_wb_master_if.master   bus
);

    localparam int DIV     = calc_div(CLK_HZ, BAUD);
    localparam int TIMER_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    state_t             state;
    logic [7:0]         rx_data;
    logic               rx_valid;
    logic               rx_err;
    logic [1:0]         data_cnt;
    logic [TIMER_W-1:0] timer;
    logic [31:0]        resp_shift;
    logic [1:0]         resp_left;

    uart_rx #(.DIV(DIV)) u_rx (
        .i_wb_clk (i_wb_clk),
        .i_wb_rst (i_wb_rst),
        .i_rx     (i_uart_rx),
        .o_data   (rx_data),
        .o_valid  (rx_valid),
        .o_err    (rx_err)
    );

    assign bus.o_resp_data = resp_shift[7:0];

    always_ff @(posedge i_wb_clk or posedge i_wb_rst) begin
        if (i_wb_rst) begin
            state            <= ST_IDLE;
            bus.o_wb_cyc     <= 1'b0;
            bus.o_wb_stb     <= 1'b0;
            bus.o_wb_we      <= 1'b0;
            bus.o_wb_addr    <= '0;
            bus.o_wb_data    <= '0;
            bus.o_resp_valid <= 1'b0;
            data_cnt         <= '0;
            timer            <= '0;
            resp_shift       <= '0;
            resp_left        <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (rx_valid) begin
                        if (rx_data == CMD_WRITE) begin
                            bus.o_wb_we <= 1'b1;
                            state       <= ST_ADDR;
                        end else if (rx_data == CMD_READ) begin
                            bus.o_wb_we <= 1'b0;
                            state       <= ST_ADDR;
                        end
                    end
                end
                ST_ADDR: begin
                    if (rx_err) begin
                        state <= ST_IDLE;
                    end else if (rx_valid) begin
                        bus.o_wb_addr <= {24'b0, rx_data};
                        if (bus.o_wb_we) begin
                            data_cnt <= '0;
                            state    <= ST_DATA;
                        end else begin
                            bus.o_wb_cyc <= 1'b1;
                            bus.o_wb_stb <= 1'b1;
                            state        <= ST_REQUEST;
                        end
                    end
                end
                ST_DATA: begin
                    if (rx_err) begin
                        state <= ST_IDLE;
                    end else if (rx_valid) begin
                        bus.o_wb_data[{data_cnt, 3'b000} +: 8] <= rx_data;
                        data_cnt <= data_cnt + 2'd1;
                        if (data_cnt == 2'd3) begin
                            bus.o_wb_cyc <= 1'b1;
                            bus.o_wb_stb <= 1'b1;
                            state        <= ST_REQUEST;
                        end
                    end
                end
                ST_REQUEST: begin
                    if (!bus.i_wb_stall) begin
                        bus.o_wb_stb <= 1'b0;
                        timer        <= TIMER_W'(TIMEOUT);
                        state        <= ST_WAIT_ACK;
                    end
                end
                ST_WAIT_ACK: begin
                    // Ack is checked first so an ack on the expiring cycle still wins.
                    if (bus.i_wb_ack) begin
                        bus.o_wb_cyc     <= 1'b0;
                        bus.o_resp_valid <= 1'b1;
                        state            <= ST_RESP;
                        if (bus.o_wb_we) begin
                            resp_shift <= {24'b0, RSP_ACK};
                            resp_left  <= 2'd0;
                        end else begin
                            resp_shift <= bus.i_wb_data;
                            resp_left  <= 2'd3;
                        end
                    end else if (timer <= TIMER_W'(1)) begin
                        bus.o_wb_cyc     <= 1'b0;
                        bus.o_resp_valid <= 1'b1;
                        resp_shift       <= {24'b0, RSP_NAK};
                        resp_left        <= 2'd0;
                        state            <= ST_RESP;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                ST_RESP: begin
                    if (bus.o_resp_valid && bus.i_resp_ready) begin
                        if (resp_left == 2'd0) begin
                            bus.o_resp_valid <= 1'b0;
                            state            <= ST_IDLE;
                        end else begin
                            resp_shift <= {8'h00, resp_shift[31:8]};
                            resp_left  <= resp_left - 2'd1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_wb_master.sv
// Scenario bench for uart_wb_master: UART frame driver, reactive wishbone slave, response monitor.
module tb_uart_wb_master;
    import uart_wb_master_pkg::*;

    localparam int CLK_HZ  = 1000000;
    localparam int BAUD    = 100000;
    localparam int TIMEOUT = 8;
    localparam int DIV     = 10;

    logic clk = 1'b0;
    logic rst;
    logic rx;

    uart_wb_master_if bus();

    uart_wb_master #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .TIMEOUT(TIMEOUT)) dut (
        .i_wb_clk  (clk),
        .i_wb_rst  (rst),
        .i_uart_rx (rx),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // slave configuration and observation state
    int          stall_left    = 0;
    int          pend_ack      = 0;
    bit          cfg_ack_en    = 1'b1;
    int          cfg_ack_delay = 1;
    logic [31:0] cfg_rdata     = 32'h0;
    int          cyc_cycles    = 0;
    int          stb_cycles    = 0;
    int          wait_cycles   = 0;
    bit          hold_err      = 1'b0;
    logic [31:0] hold_addr, hold_data;
    logic [7:0]  resp_q[$];
    logic        acc_we_q[$];
    logic [31:0] acc_addr_q[$];
    logic [31:0] acc_data_q[$];

    // reference model output
    logic [7:0]  exp_resp[$];
    logic        exp_we[$];
    logic [31:0] exp_addr[$];
    logic [31:0] exp_data[$];

    initial begin
        bus.i_wb_stall = 1'b0;
        bus.i_wb_ack   = 1'b0;
        bus.i_wb_data  = 32'h0;
        forever begin
            @(negedge clk);
            if (bus.o_resp_valid && bus.i_resp_ready) resp_q.push_back(bus.o_resp_data);
            if (bus.o_wb_cyc) begin
                if (cyc_cycles == 0) begin
                    hold_addr = bus.o_wb_addr;
                    hold_data = bus.o_wb_data;
                end else if (bus.o_wb_addr !== hold_addr || bus.o_wb_data !== hold_data) begin
                    hold_err = 1'b1;
                end
                cyc_cycles++;
                if (bus.o_wb_stb) stb_cycles++;
                else wait_cycles++;
            end
            bus.i_wb_ack  = 1'b0;
            bus.i_wb_data = $urandom;
            if (pend_ack > 0) begin
                pend_ack--;
                if (pend_ack == 0 && bus.o_wb_cyc) begin
                    bus.i_wb_ack  = 1'b1;
                    bus.i_wb_data = cfg_rdata;
                end
            end
            if (bus.o_wb_cyc && bus.o_wb_stb) begin
                if (stall_left > 0) begin
                    bus.i_wb_stall = 1'b1;
                    stall_left--;
                end else begin
                    bus.i_wb_stall = 1'b0;
                    acc_we_q.push_back(bus.o_wb_we);
                    acc_addr_q.push_back(bus.o_wb_addr);
                    acc_data_q.push_back(bus.o_wb_data);
                    if (cfg_ack_en) pend_ack = cfg_ack_delay;
                end
            end else begin
                bus.i_wb_stall = 1'b0;
            end
        end
    end

    task automatic clear_mon();
        cyc_cycles = 0; stb_cycles = 0; wait_cycles = 0; hold_err = 1'b0;
        pend_ack = 0; stall_left = 0;
        resp_q.delete(); acc_we_q.delete(); acc_addr_q.delete(); acc_data_q.delete();
        exp_resp.delete(); exp_we.delete(); exp_addr.delete(); exp_data.delete();
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        logic [9:0] frame;
        frame = {stop_bit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx = frame[i];
            repeat (DIV) @(posedge clk);
            #1;
        end
        rx = 1'b1;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic send_write(input logic [7:0] a, input logic [31:0] d);
        send_byte(CMD_WRITE, 1'b1);
        send_byte(a, 1'b1);
        for (int i = 0; i < 4; i++) send_byte(d[8*i +: 8], 1'b1);
    endtask

    task automatic send_read(input logic [7:0] a);
        send_byte(CMD_READ, 1'b1);
        send_byte(a, 1'b1);
    endtask

    task automatic wait_resp(input int n);
        int c;
        c = 0;
        while (resp_q.size() < n && c < 500) begin
            @(negedge clk);
            c++;
        end
        repeat (20) @(negedge clk);
    endtask

    // Expected bus transaction and response bytes of one complete frame.
    task automatic model_frame(input bit is_wr, input logic [7:0] a, input logic [31:0] d,
                               input bit acked, input logic [31:0] rd);
        exp_we.push_back(is_wr);
        exp_addr.push_back({24'h0, a});
        exp_data.push_back(d);
        if (!acked) exp_resp.push_back(8'h15);
        else if (is_wr) exp_resp.push_back(8'h06);
        else for (int i = 0; i < 4; i++) exp_resp.push_back(8'((rd >> (8 * i)) & 32'hFF));
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rx = 1'b1;
        bus.i_resp_ready = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++; if (bus.o_wb_cyc !== 1'b0) $display("FAIL reset_cyc got=%b exp=0", bus.o_wb_cyc); else n_pass++;
        n_checks++; if (bus.o_wb_stb !== 1'b0) $display("FAIL reset_stb got=%b exp=0", bus.o_wb_stb); else n_pass++;
        n_checks++; if (bus.o_wb_we !== 1'b0) $display("FAIL reset_we got=%b exp=0", bus.o_wb_we); else n_pass++;
        n_checks++; if (bus.o_wb_addr !== 32'h0) $display("FAIL reset_addr got=%h exp=0", bus.o_wb_addr); else n_pass++;
        n_checks++; if (bus.o_wb_data !== 32'h0) $display("FAIL reset_data got=%h exp=0", bus.o_wb_data); else n_pass++;
        n_checks++; if (bus.o_resp_valid !== 1'b0) $display("FAIL reset_rvalid got=%b exp=0", bus.o_resp_valid); else n_pass++;
        n_checks++; if (bus.o_resp_data !== 8'h0) $display("FAIL reset_rdata got=%h exp=0", bus.o_resp_data); else n_pass++;
        rst = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_write();
        logic [7:0]  a;
        logic [31:0] d;
        for (int it = 0; it < 3; it++) begin
            a = (it == 0) ? 8'h01 : 8'($urandom);
            d = (it == 0) ? 32'h0000000F : $urandom;
            clear_mon();
            cfg_ack_en = 1'b1; cfg_ack_delay = 1;
            send_write(a, d);
            wait_resp(1);
            n_checks++; if (acc_we_q.size() != 1) $display("FAIL wr_accepts got=%0d exp=1", acc_we_q.size()); else n_pass++;
            if (acc_we_q.size() > 0) begin
                n_checks++; if (acc_we_q[0] !== 1'b1) $display("FAIL wr_we got=%b exp=1", acc_we_q[0]); else n_pass++;
                n_checks++; if (acc_addr_q[0] !== {24'h0, a}) $display("FAIL wr_addr got=%h exp=%h", acc_addr_q[0], {24'h0, a}); else n_pass++;
                n_checks++; if (acc_data_q[0] !== d) $display("FAIL wr_data got=%h exp=%h", acc_data_q[0], d); else n_pass++;
            end
            n_checks++; if (stb_cycles != 1) $display("FAIL wr_stb_cycles got=%0d exp=1", stb_cycles); else n_pass++;
            n_checks++; if (cyc_cycles != 2) $display("FAIL wr_cyc_cycles got=%0d exp=2", cyc_cycles); else n_pass++;
            n_checks++; if (resp_q.size() != 1 || resp_q[0] !== 8'h06) $display("FAIL wr_resp got_n=%0d got0=%h exp=06", resp_q.size(), (resp_q.size() > 0) ? resp_q[0] : 8'hxx); else n_pass++;
        end
    endtask

    task automatic test_read();
        logic [7:0]  a;
        int c;
        for (int it = 0; it < 3; it++) begin
            a = (it == 0) ? 8'h02 : 8'($urandom);
            clear_mon();
            cfg_rdata = (it == 0) ? 32'hDEADBEEF : $urandom;
            cfg_ack_en = 1'b1; cfg_ack_delay = (it == 0) ? 1 : $urandom_range(1, 3);
            model_frame(1'b0, a, 32'h0, 1'b1, cfg_rdata);
            if (it == 0) bus.i_resp_ready = 1'b0;
            send_read(a);
            if (it == 0) begin
                c = 0;
                while (!bus.o_resp_valid && c < 100) begin @(negedge clk); c++; end
                n_checks++; if (bus.o_resp_valid !== 1'b1) $display("FAIL rd_valid_wait got=%b exp=1", bus.o_resp_valid); else n_pass++;
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    n_checks++; if ({bus.o_resp_valid, bus.o_resp_data} !== {1'b1, 8'hEF}) $display("FAIL rd_hold cyc=%0d got=%b/%h exp=1/ef", k, bus.o_resp_valid, bus.o_resp_data); else n_pass++;
                end
                @(posedge clk); #1;
                bus.i_resp_ready = 1'b1;
            end
            wait_resp(4);
            n_checks++; if (acc_we_q.size() != 1) $display("FAIL rd_accepts got=%0d exp=1", acc_we_q.size()); else n_pass++;
            if (acc_we_q.size() > 0) begin
                n_checks++; if (acc_we_q[0] !== 1'b0) $display("FAIL rd_we got=%b exp=0", acc_we_q[0]); else n_pass++;
                n_checks++; if (acc_addr_q[0] !== exp_addr[0]) $display("FAIL rd_addr got=%h exp=%h", acc_addr_q[0], exp_addr[0]); else n_pass++;
            end
            n_checks++; if (resp_q.size() != exp_resp.size()) $display("FAIL rd_resp_count got=%0d exp=%0d", resp_q.size(), exp_resp.size()); else n_pass++;
            for (int i = 0; i < exp_resp.size() && i < resp_q.size(); i++) begin
                n_checks++; if (resp_q[i] !== exp_resp[i]) $display("FAIL rd_resp_byte%0d got=%h exp=%h", i, resp_q[i], exp_resp[i]); else n_pass++;
            end
        end
    endtask

    task automatic test_stall();
        int st;
        for (int it = 0; it < 3; it++) begin
            st = (it == 0) ? 3 : $urandom_range(0, 5);
            clear_mon();
            stall_left = st;
            cfg_ack_en = 1'b1; cfg_ack_delay = $urandom_range(1, 3);
            send_write(8'($urandom), $urandom);
            wait_resp(1);
            n_checks++; if (stb_cycles != st + 1) $display("FAIL stall_stb_cycles got=%0d exp=%0d", stb_cycles, st + 1); else n_pass++;
            n_checks++; if (acc_we_q.size() != 1) $display("FAIL stall_accepts got=%0d exp=1", acc_we_q.size()); else n_pass++;
            n_checks++; if (hold_err !== 1'b0) $display("FAIL stall_hold got=%b exp=0", hold_err); else n_pass++;
            n_checks++; if (resp_q.size() != 1 || resp_q[0] !== 8'h06) $display("FAIL stall_resp got_n=%0d got0=%h exp=06", resp_q.size(), (resp_q.size() > 0) ? resp_q[0] : 8'hxx); else n_pass++;
        end
    endtask

    task automatic test_timeout();
        clear_mon();
        cfg_ack_en = 1'b0;
        send_write(8'($urandom), $urandom);
        wait_resp(1);
        n_checks++; if (wait_cycles != TIMEOUT) $display("FAIL to_cyc_after_accept got=%0d exp=%0d", wait_cycles, TIMEOUT); else n_pass++;
        n_checks++; if (acc_we_q.size() != 1) $display("FAIL to_accepts got=%0d exp=1", acc_we_q.size()); else n_pass++;
        n_checks++; if (resp_q.size() != 1 || resp_q[0] !== 8'h15) $display("FAIL to_resp got_n=%0d got0=%h exp=15", resp_q.size(), (resp_q.size() > 0) ? resp_q[0] : 8'hxx); else n_pass++;
        clear_mon();
        cfg_ack_en = 1'b1; cfg_ack_delay = 1;
        send_write(8'($urandom), $urandom);
        wait_resp(1);
        n_checks++; if (cyc_cycles != 2) $display("FAIL to_next_cyc_cycles got=%0d exp=2", cyc_cycles); else n_pass++;
        n_checks++; if (resp_q.size() != 1 || resp_q[0] !== 8'h06) $display("FAIL to_next_resp got_n=%0d got0=%h exp=06", resp_q.size(), (resp_q.size() > 0) ? resp_q[0] : 8'hxx); else n_pass++;
    endtask

    task automatic test_ignored_byte();
        clear_mon();
        cfg_ack_en = 1'b1; cfg_ack_delay = 2; cfg_rdata = $urandom;
        send_byte(8'h41, 1'b1);
        send_read(8'h00);
        wait_resp(4);
        n_checks++; if (acc_we_q.size() != 1) $display("FAIL ign_accepts got=%0d exp=1", acc_we_q.size()); else n_pass++;
        if (acc_we_q.size() > 0) begin
            n_checks++; if ({acc_we_q[0], acc_addr_q[0]} !== {1'b0, 32'h0}) $display("FAIL ign_we_addr got=%b/%h exp=0/0", acc_we_q[0], acc_addr_q[0]); else n_pass++;
        end
        n_checks++; if (resp_q.size() != 4) $display("FAIL ign_resp_count got=%0d exp=4", resp_q.size()); else n_pass++;
    endtask

    task automatic test_framing();
        clear_mon();
        cfg_ack_en = 1'b1; cfg_ack_delay = 1;
        send_byte(CMD_WRITE, 1'b1);
        send_byte(8'($urandom), 1'b1);
        send_byte(8'($urandom), 1'b0);
        repeat (150) @(negedge clk);
        n_checks++; if (cyc_cycles != 0) $display("FAIL frm_cyc got=%0d exp=0", cyc_cycles); else n_pass++;
        n_checks++; if (resp_q.size() != 0 || bus.o_resp_valid !== 1'b0) $display("FAIL frm_resp got_n=%0d valid=%b exp=0/0", resp_q.size(), bus.o_resp_valid); else n_pass++;
        cfg_rdata = $urandom;
        model_frame(1'b0, 8'h33, 32'h0, 1'b1, cfg_rdata);
        send_read(8'h33);
        wait_resp(4);
        n_checks++; if (acc_we_q.size() != 1) $display("FAIL frm_recover_accepts got=%0d exp=1", acc_we_q.size()); else n_pass++;
        n_checks++; if (resp_q.size() != 4 || resp_q[0] !== exp_resp[0]) $display("FAIL frm_recover_resp got_n=%0d exp_n=4", resp_q.size()); else n_pass++;
    endtask

    task automatic test_reset_wait_ack();
        int c;
        clear_mon();
        cfg_ack_en = 1'b0;
        send_read(8'($urandom));
        c = 0;
        while (!(bus.o_wb_cyc && !bus.o_wb_stb) && c < 100) begin @(negedge clk); c++; end
        n_checks++; if (bus.o_wb_cyc !== 1'b1) $display("FAIL rstw_reach_wait got=%b exp=1", bus.o_wb_cyc); else n_pass++;
        #2 rst = 1'b1;
        #1;
        n_checks++; if ({bus.o_wb_cyc, bus.o_wb_stb} !== 2'b00) $display("FAIL rstw_async_drop got=%b exp=00", {bus.o_wb_cyc, bus.o_wb_stb}); else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        n_checks++; if (resp_q.size() != 0 || bus.o_resp_valid !== 1'b0) $display("FAIL rstw_no_resp got_n=%0d valid=%b exp=0/0", resp_q.size(), bus.o_resp_valid); else n_pass++;
        cfg_ack_en = 1'b1;
    endtask

    task automatic test_back_to_back();
        bit          is_wr, acked;
        logic [7:0]  a, junk;
        logic [31:0] d;
        clear_mon();
        for (int f = 0; f < 6; f++) begin
            is_wr = 1'($urandom);
            acked = ($urandom_range(0, 4) != 0);
            a = 8'($urandom);
            d = $urandom;
            cfg_ack_en = acked;
            cfg_ack_delay = $urandom_range(1, 3);
            cfg_rdata = $urandom;
            stall_left = $urandom_range(0, 2);
            if ($urandom_range(0, 1) == 1) begin
                junk = 8'($urandom);
                if (junk == CMD_WRITE || junk == CMD_READ) junk = 8'h00;
                send_byte(junk, 1'b1);
            end
            model_frame(is_wr, a, d, acked, cfg_rdata);
            if (is_wr) send_write(a, d);
            else send_read(a);
            wait_resp(exp_resp.size());
        end
        n_checks++; if (acc_we_q.size() != exp_we.size()) $display("FAIL b2b_accepts got=%0d exp=%0d", acc_we_q.size(), exp_we.size()); else n_pass++;
        for (int i = 0; i < exp_we.size() && i < acc_we_q.size(); i++) begin
            n_checks++; if ({acc_we_q[i], acc_addr_q[i]} !== {exp_we[i], exp_addr[i]}) $display("FAIL b2b_req%0d got=%b/%h exp=%b/%h", i, acc_we_q[i], acc_addr_q[i], exp_we[i], exp_addr[i]); else n_pass++;
            if (exp_we[i]) begin
                n_checks++; if (acc_data_q[i] !== exp_data[i]) $display("FAIL b2b_wdata%0d got=%h exp=%h", i, acc_data_q[i], exp_data[i]); else n_pass++;
            end
        end
        n_checks++; if (resp_q.size() != exp_resp.size()) $display("FAIL b2b_resp_count got=%0d exp=%0d", resp_q.size(), exp_resp.size()); else n_pass++;
        for (int i = 0; i < exp_resp.size() && i < resp_q.size(); i++) begin
            n_checks++; if (resp_q[i] !== exp_resp[i]) $display("FAIL b2b_resp%0d got=%h exp=%h", i, resp_q[i], exp_resp[i]); else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_stall();
        test_timeout();
        test_ignored_byte();
        test_framing();
        test_reset_wait_ack();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_wb_master.md
Name: uart_wb_master

Overview:
- Upstream wishbone master for the board: receives framed commands on a UART RX pin and issues single pipelined-wishbone reads/writes to peripherals such as wb_led_pwm.
- Replaces the hard-coded request sequencer in the top level, so PWM and other registers can be driven from a host.
- Returns a response byte stream (ack/NAK/read data) to a separate UART transmitter through a valid/ready port.

Parameters:
- CLK_HZ, 48000000, system clock frequency in Hz.
- BAUD, 115200, UART bit rate; DIV = CLK_HZ/BAUD, integer-truncated, minimum 4.
- TIMEOUT, 255, maximum cycles to wait for i_wb_ack after a request is accepted.

Ports:
- i_wb_clk  in  1  system clock.
- i_wb_rst  in  1  reset: asynchronous assert, active-high.
- i_uart_rx  in  1  serial input, 8N1, idle high; asynchronous to the clock.
- o_wb_cyc  out  1  bus cycle.
- o_wb_stb  out  1  request strobe.
- o_wb_we  out  1  1 = write.
- o_wb_addr  out  32  {24'b0, addr byte}.
- o_wb_data  out  32  write data.
- i_wb_data  in  32  read data, valid with ack.
- i_wb_stall  in  1  slave not accepting the request.
- i_wb_ack  in  1  transfer complete.
- o_resp_valid  out  1  response byte available.
- o_resp_data  out  8  response byte.
- i_resp_ready  in  1  consumer takes the byte.

Behaviour:
- Reset: all outputs 0; FSM in IDLE; UART receiver in idle; all counters 0.
- RX front end:
  - 2-flop synchronizer on i_uart_rx.
  - Start bit detected on a synchronized 1->0 edge; re-checked low at DIV/2; sampled every DIV cycles thereafter, LSB first.
  - Stop bit sampled high: emit a 1-cycle byte strobe.
  - Stop bit sampled low (framing error): byte discarded and a 1-cycle err strobe emitted.
  - Byte strobe occurs (9.5*DIV)+3 cycles (±1) after the start edge.
- Frame format:
  - Write: 0x57 'W', addr, d0, d1, d2, d3 (little-endian).
  - Read: 0x52 'R', addr.
- FSM states: IDLE, ADDR, DATA, REQUEST, WAIT_ACK, RESP.
  - IDLE: 'W' sets we=1; 'R' sets we=0; both go to ADDR. Any other byte is ignored and the FSM stays in IDLE.
  - ADDR: latch addr byte. Write goes to DATA with cnt=0; read goes to REQUEST.
  - DATA: shift bytes into data[8*cnt +: 8]; after the 4th byte go to REQUEST.
  - REQUEST: cyc=1, stb=1. If !i_wb_stall on a clock edge, the request is accepted: drop stb, go to WAIT_ACK, clear the timer.
  - WAIT_ACK: cyc=1, stb=0.
    - i_wb_ack: capture i_wb_data on a read; drop cyc; go to RESP.
    - Timer reaching TIMEOUT first: drop cyc; go to RESP with response NAK.
    - Ack arriving in the same cycle the timer expires counts as success.
  - RESP: present bytes on o_resp_*; advance only on valid&&ready; o_resp_data held stable while valid&&!ready.
    - Write success: 0x06.
    - Read success: 4 bytes, LSB first.
    - Timeout: 0x15.
    - After the last byte: IDLE.
- Bus outputs: o_wb_cyc/o_wb_stb/o_wb_we/o_wb_addr/o_wb_data are registered. o_wb_addr and o_wb_data hold their values from entry to REQUEST until leaving WAIT_ACK.
- A framing error in ADDR or DATA aborts the frame to IDLE with no bus cycle and no response.
- Bytes received during REQUEST, WAIT_ACK or RESP are dropped; there is no queueing.
- i_wb_ack seen while cyc=0 is ignored.
- i_wb_rst mid-transaction: cyc/stb drop asynchronously; any pending response is lost.

Decomposition:
- Shared package: command byte constants (CMD_WRITE=8'h57, CMD_READ=8'h52, RSP_ACK=8'h06, RSP_NAK=8'h15) and the FSM state encoding.
- One sub-module, uart_rx:
  - Parameter DIV.
  - Ports: i_wb_clk, i_wb_rst, i_rx, o_data[7:0], o_valid, o_err.
  - Holds the synchronizer, bit counter and baud counter.

Test Plan (bench uses CLK_HZ=1000000, BAUD=100000, so DIV=10):
- Write frame 57 01 0F 00 00 00, slave stall=0, ack 1 cycle after acceptance -> one stb pulse with addr=0x00000001, data=0x0000000F, we=1; cyc high for 2 cycles; resp 0x06.
- Read frame 52 02, slave returns 0xDEADBEEF with ack -> we=0, addr=0x2; resp bytes EF BE AD DE in order; i_resp_ready held low for 5 cycles -> byte EF stays stable throughout.
- Stall held 3 cycles on write -> stb high 4 cycles with constant addr/data; exactly one acceptance; ack then resp 0x06.
- No ack with TIMEOUT=8 -> cyc drops 8 cycles after acceptance; resp 0x15; a subsequent valid frame works normally.
- Byte 0x41 then read frame 52 00 -> 0x41 ignored; single read cycle to addr 0.
- Framing error (stop bit 0) on the 3rd byte of a write frame -> no cyc; no resp; FSM back in IDLE.
- i_wb_rst asserted during WAIT_ACK -> cyc/stb 0 immediately; no resp.
